// File: rtl/block_interleaver_v2_if.sv
// Stream handshake bundle used on both sides of the block interleaver.
// master drives data/valid/last/user and samples ready; slave is the mirror.
interface block_interleaver_v2_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic              tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/block_interleaver_v2.sv
// Transmit-side block interleaver with ping/pong block buffers.
// Words arrive column-ordered (row index fast) and leave row-ordered
// (column index fast). One buffer fills while the other drains.
module block_interleaver_v2 #(
    parameter int FRAME_SIZE_IN_WORDS = 70,
    parameter int NUM_CODEWORDS       = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    block_interleaver_v2_if.slave  s_axis,
    block_interleaver_v2_if.master m_axis
);
    localparam int F  = FRAME_SIZE_IN_WORDS;
    localparam int N  = NUM_CODEWORDS;
    localparam int T  = F * N;
    localparam int AW = $clog2(2 * T);
    localparam int PW = $clog2(T);
    localparam int CW = (F > 1) ? $clog2(F) : 1;
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    logic [31:0]   mem_r [0:2*T-1];

    logic [SW-1:0] wr_sel_r;
    logic [CW-1:0] wr_col_r;
    logic          wr_buf_r;
    logic          rd_buf_r;
    logic [1:0]    full_r;
    logic [PW-1:0] rd_ptr_r;
    logic          s_tready_r;
    logic [31:0]   m_tdata_r;
    logic          m_tvalid_r;
    logic          m_tlast_r;
    logic          m_tuser_r;

    logic          wr_fire_s;
    logic          wr_row_end_s;
    logic          wr_done_s;
    logic          rd_load_s;
    logic          rd_done_s;
    logic [1:0]    full_nxt_s;
    logic          wr_buf_nxt_s;
    logic [AW-1:0] wr_addr_s;
    logic [AW-1:0] rd_addr_s;

    // Handshake decode, next-state buffer flags and buffer addressing.
    always_comb begin
        wr_fire_s    = s_axis.tvalid && s_tready_r && !flush_i;
        wr_row_end_s = (wr_sel_r == SW'(N - 1));
        wr_done_s    = wr_fire_s && wr_row_end_s && (wr_col_r == CW'(F - 1));
        rd_load_s    = full_r[rd_buf_r] && (!m_tvalid_r || m_axis.tready);
        rd_done_s    = rd_load_s && (rd_ptr_r == PW'(T - 1));
        // Release and completion always hit different buffers, so both apply.
        full_nxt_s[0] = (full_r[0] && !(rd_done_s && !rd_buf_r)) || (wr_done_s && !wr_buf_r);
        full_nxt_s[1] = (full_r[1] && !(rd_done_s &&  rd_buf_r)) || (wr_done_s &&  wr_buf_r);
        wr_buf_nxt_s  = wr_buf_r ^ wr_done_s;
        wr_addr_s = (wr_buf_r ? AW'(T) : AW'(0)) + AW'(wr_sel_r) * AW'(F) + AW'(wr_col_r);
        rd_addr_s = (rd_buf_r ? AW'(T) : AW'(0)) + AW'(rd_ptr_r);
    end

    // Write pointers: row index fast, column index slow; flush restarts the block.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_sel_r <= SW'(0);
            wr_col_r <= CW'(0);
            wr_buf_r <= 1'b0;
        end else if (flush_i) begin
            wr_sel_r <= SW'(0);
            wr_col_r <= CW'(0);
        end else if (wr_fire_s) begin
            if (wr_row_end_s) begin
                wr_sel_r <= SW'(0);
                if (wr_col_r == CW'(F - 1)) begin
                    wr_col_r <= CW'(0);
                end else begin
                    wr_col_r <= wr_col_r + CW'(1);
                end
            end else begin
                wr_sel_r <= wr_sel_r + SW'(1);
            end
            wr_buf_r <= wr_buf_nxt_s;
        end
    end

    // Block storage: data words only, no reset needed.
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            mem_r[wr_addr_s] <= s_axis.tdata;
        end
    end

    // Buffer full flags and input ready, ready looks at the post-edge flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_r     <= 2'b00;
            s_tready_r <= 1'b0;
        end else begin
            full_r     <= full_nxt_s;
            s_tready_r <= !full_nxt_s[wr_buf_nxt_s];
        end
    end

    // Read pointer and output register; holds its word while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_buf_r   <= 1'b0;
            rd_ptr_r   <= PW'(0);
            m_tdata_r  <= 32'd0;
            m_tvalid_r <= 1'b0;
            m_tlast_r  <= 1'b0;
            m_tuser_r  <= 1'b0;
        end else if (rd_load_s) begin
            m_tdata_r  <= mem_r[rd_addr_s];
            m_tvalid_r <= 1'b1;
            m_tlast_r  <= (rd_ptr_r == PW'(T - 1));
            m_tuser_r  <= (rd_ptr_r == PW'(0));
            if (rd_done_s) begin
                rd_ptr_r <= PW'(0);
                rd_buf_r <= ~rd_buf_r;
            end else begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
        end else if (m_axis.tready) begin
            m_tvalid_r <= 1'b0;
        end
    end

    assign s_axis.tready = s_tready_r;
    assign m_axis.tdata  = m_tdata_r;
    assign m_axis.tvalid = m_tvalid_r;
    assign m_axis.tlast  = m_tlast_r;
    assign m_axis.tuser  = m_tuser_r;
endmodule

// File: tb/tb_block_interleaver_v2.sv
// Self-checking bench for block_interleaver_v2 with F=4, N=2.
module tb_block_interleaver_v2;
    localparam int F = 4;
    localparam int N = 2;
    localparam int T = F * N;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic flush = 1'b0;

    block_interleaver_v2_if s_if ();
    block_interleaver_v2_if m_if ();

    block_interleaver_v2 #(
        .FRAME_SIZE_IN_WORDS(F),
        .NUM_CODEWORDS      (N)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .flush_i(flush),
        .s_axis (s_if),
        .m_axis (m_if)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        user;
    } word_t;

    typedef struct {
        logic [31:0] din;
        logic [31:0] dout;
        logic        last;
        logic        user;
    } vec_t;

    vec_t        tbl [8];
    word_t       exp_q [$];
    word_t       got_q [$];
    logic [31:0] cur_q [$];
    int          out_cyc_q [$];
    int          tests = 0;
    int          fails = 0;
    int          ncyc  = 0;
    bit          in_fired, out_fired, s_rdy_smp, prev_stall;
    word_t       prev_w;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: a completed column-ordered block re-read row by row.
    task automatic model_block();
        word_t w;
        for (int k = 0; k < T; k++) begin
            int r = k / F;
            int c = k % F;
            w.data = cur_q[c * N + r];
            w.last = (k == T - 1);
            w.user = (k == 0);
            exp_q.push_back(w);
        end
        cur_q.delete();
    endtask

    // One clock: observe at negedge, feed model, compare outputs, return at posedge+1.
    task automatic cycle();
        word_t w;
        word_t e;
        @(negedge clk);
        ncyc++;
        in_fired  = 1'b0;
        out_fired = 1'b0;
        s_rdy_smp = s_if.tready;
        if (rst) begin
            cur_q.delete();
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            w.data = m_if.tdata;
            w.last = m_if.tlast;
            w.user = m_if.tuser;
            if (prev_stall) begin
                check("stall_valid", m_if.tvalid, 1);
                check("stall_data", w.data, prev_w.data);
                check("stall_flags", {w.last, w.user}, {prev_w.last, prev_w.user});
            end
            if (flush) begin
                cur_q.delete();
            end else if (s_if.tvalid && s_if.tready) begin
                in_fired = 1'b1;
                cur_q.push_back(s_if.tdata);
                if (cur_q.size() == T) model_block();
            end
            if (m_if.tvalid && m_if.tready) begin
                out_fired = 1'b1;
                got_q.push_back(w);
                out_cyc_q.push_back(ncyc);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got %0h expected none", w.data);
                end else begin
                    e = exp_q.pop_front();
                    check("model_data", w.data, e.data);
                    check("model_tlast", w.last, e.last);
                    check("model_tuser", w.user, e.user);
                end
            end
            prev_stall = m_if.tvalid && !m_if.tready;
            prev_w     = w;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d, output int waited);
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        waited      = 0;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (in_fired) break;
            waited++;
        end
        check("send_accepted", in_fired, 1);
        s_if.tvalid = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < 500 && got_q.size() < n; i++) cycle();
        check("drain_count", got_q.size(), n);
    endtask

    task automatic send_table();
        int w;
        for (int i = 0; i < 8; i++) send_word(tbl[i].din, w);
    endtask

    task automatic compare_table(input string tag);
        if (got_q.size() >= 8) begin
            for (int i = 0; i < 8; i++) begin
                check({tag, "_data"}, got_q[i].data, tbl[i].dout);
                check({tag, "_tlast"}, got_q[i].last, tbl[i].last);
                check({tag, "_tuser"}, got_q[i].user, tbl[i].user);
            end
        end
    endtask

    initial begin
        int w;
        int stalls;
        int n7;
        int reads;
        bit found;

        tbl[0] = '{32'd0, 32'd0, 1'b0, 1'b1};
        tbl[1] = '{32'd1, 32'd2, 1'b0, 1'b0};
        tbl[2] = '{32'd2, 32'd4, 1'b0, 1'b0};
        tbl[3] = '{32'd3, 32'd6, 1'b0, 1'b0};
        tbl[4] = '{32'd4, 32'd1, 1'b0, 1'b0};
        tbl[5] = '{32'd5, 32'd3, 1'b0, 1'b0};
        tbl[6] = '{32'd6, 32'd5, 1'b0, 1'b0};
        tbl[7] = '{32'd7, 32'd7, 1'b1, 1'b0};

        s_if.tvalid = 1'b0;
        s_if.tdata  = 32'd0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
        m_if.tready = 1'b0;

        // Reset state
        repeat (2) cycle();
        check("rst_s_tready", s_if.tready, 0);
        check("rst_m_tvalid", m_if.tvalid, 0);
        check("rst_m_tdata", m_if.tdata, 0);
        check("rst_m_tlast", m_if.tlast, 0);
        check("rst_m_tuser", m_if.tuser, 0);
        rst = 1'b0;
        cycle();
        check("rst_release_tready", s_if.tready, 1);

        // 1: single block, table-driven, latency
        m_if.tready = 1'b1;
        got_q.delete();
        out_cyc_q.delete();
        send_table();
        n7 = ncyc;
        drain(8);
        if (out_cyc_q.size() > 0) check("t1_latency", out_cyc_q[0] - n7, 2);
        compare_table("t1");

        // 2: three back-to-back blocks, no bubbles, ready never drops
        got_q.delete();
        out_cyc_q.delete();
        stalls = 0;
        for (int i = 0; i < 24; i++) begin
            send_word(32'd100 + 32'(i), w);
            stalls += w;
        end
        drain(24);
        check("t2_s_tready_drops", stalls, 0);
        if (out_cyc_q.size() >= 24) check("t2_no_bubbles", out_cyc_q[23] - out_cyc_q[0], 23);

        // 3: downstream stalled, both buffers fill, ready drops then recovers
        m_if.tready = 1'b0;
        got_q.delete();
        stalls = 0;
        for (int i = 0; i < 16; i++) begin
            send_word(32'd200 + 32'(i), w);
            stalls += w;
        end
        check("t3_16_accepted", stalls, 0);
        repeat (4) begin
            cycle();
            check("t3_blocked", s_rdy_smp, 0);
        end
        m_if.tready = 1'b1;
        reads = 0;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            cycle();
            if (out_fired) reads++;
            if (s_rdy_smp) begin
                found = 1'b1;
                break;
            end
        end
        check("t3_ready_returns", found, 1);
        check("t3_reads_before_ready", reads, 8);
        drain(16);
        check("t3_words_lost", exp_q.size(), 0);

        // 4: flush a partial block, then flush together with a fire
        for (int i = 0; i < 5; i++) send_word(32'd900 + 32'(i), w);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        got_q.delete();
        send_table();
        drain(8);
        compare_table("t4_flush");
        flush       = 1'b1;
        s_if.tvalid = 1'b1;
        s_if.tdata  = 32'd777;
        cycle();
        flush       = 1'b0;
        s_if.tvalid = 1'b0;
        got_q.delete();
        send_table();
        drain(8);
        compare_table("t4_flush_fire");

        // 5: random valid/ready/flush against the reference model
        got_q.delete();
        for (int c = 0; c < 60000 && got_q.size() < 1000 * T; c++) begin
            if (!s_if.tvalid || in_fired) begin
                s_if.tvalid = ($urandom_range(0, 9) < 7);
                s_if.tdata  = $urandom;
            end
            m_if.tready = ($urandom_range(0, 9) < 6);
            flush       = ($urandom_range(0, 999) == 0);
            cycle();
        end
        flush       = 1'b0;
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
        repeat (30) cycle();
        check("t5_enough_words", got_q.size() >= 1000 * T, 1);
        check("t5_pending", exp_q.size(), 0);

        // 6: reset while a block is being output
        flush = 1'b1;
        cycle();
        flush       = 1'b0;
        m_if.tready = 1'b0;
        send_table();
        repeat (3) cycle();
        m_if.tready = 1'b1;
        repeat (2) cycle();
        rst = 1'b1;
        cycle();
        check("t6_s_tready", s_if.tready, 0);
        check("t6_m_tvalid", m_if.tvalid, 0);
        check("t6_m_tdata", m_if.tdata, 0);
        check("t6_m_tlast", m_if.tlast, 0);
        check("t6_m_tuser", m_if.tuser, 0);
        rst = 1'b0;
        cycle();
        check("t6_tready_back", s_if.tready, 1);
        got_q.delete();
        send_table();
        drain(8);
        compare_table("t6_fresh");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
